// File: rtl/osc_mon_pkg.sv
// Shared types and constants for the oscillator frequency monitor.
// Holds the FSM state type, default parameters and range-bound helper.
package osc_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      GATE,
      EVAL
   } state_t;

   localparam int SYNC_STAGES_D = 2;
   localparam int GATE_CYCLES_D = 50000;
   localparam int EXP_COUNT_D   = 1000;
   localparam int TOL_D         = 10;
   localparam int CNT_W_D       = 16;
   localparam int GATE_W_D      = 16;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } bounds_t;

   // Inclusive acceptance window, lower clamped at 0, upper at counter max.
   // A lower bound above the clamped upper bound yields an empty range.
   function automatic bounds_t calc_bounds(
      input int exp_count,
      input int tol,
      input int cnt_w
   );
      longint  max_v;
      longint  lo_v;
      longint  hi_v;
      bounds_t b;
      max_v = (longint'(1) << cnt_w) - 1;
      lo_v  = longint'(exp_count) - longint'(tol);
      hi_v  = longint'(exp_count) + longint'(tol);
      if (lo_v < 0) lo_v = 0;
      if (hi_v > max_v) hi_v = max_v;
      b.lo = 32'(lo_v);
      b.hi = 32'(hi_v);
      return b;
   endfunction

endpackage

// File: rtl/osc_freq_monitor_if.sv
// Control and result bundle of the oscillator frequency monitor.
// master = firmware/bench side, slave = monitor side.
interface osc_freq_monitor_if
   import osc_mon_pkg::*;
#(
   parameter int CNT_W = CNT_W_D
) ();

   logic             ENABLE;
   logic             MON_CLK;
   logic             FAULT_CLR;
   logic [CNT_W-1:0] MEAS_COUNT;
   logic             MEAS_VALID;
   logic             FREQ_OK;
   logic             FREQ_FAULT;
   logic             STUCK;

   modport master (
      output ENABLE, MON_CLK, FAULT_CLR,
      input  MEAS_COUNT, MEAS_VALID, FREQ_OK, FREQ_FAULT, STUCK
   );

   modport slave (
      input  ENABLE, MON_CLK, FAULT_CLR,
      output MEAS_COUNT, MEAS_VALID, FREQ_OK, FREQ_FAULT, STUCK
   );

endinterface

// File: rtl/osc_mon_sync_edge.sv
// Multi-flop synchroniser plus registered rising-edge detector.
// Pulse appears STAGES+1 clocks after the async input rises.
module osc_mon_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the async input in and flag sync=1 with previous=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
         pulse  <= sync_q[STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts MON_CLK edges over a fixed gate window and flags off-frequency.
// Define OSC_MON_FILTER_EN to require two consecutive bad windows.
module osc_freq_monitor
   import osc_mon_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_D,
   parameter int GATE_CYCLES = GATE_CYCLES_D,
   parameter int EXP_COUNT   = EXP_COUNT_D,
   parameter int TOL         = TOL_D,
   parameter int CNT_W       = CNT_W_D,
   parameter int GATE_W      = GATE_W_D
) (
   input logic               CLK,
   input logic               RESET,
   osc_freq_monitor_if.slave mon
);

   localparam bounds_t          BND       = calc_bounds(EXP_COUNT, TOL, CNT_W);
   localparam logic [31:0]      LO        = BND.lo;
   localparam logic [31:0]      HI        = BND.hi;
   localparam logic             EMPTY     = (LO > HI);
   localparam logic [31:0]      SPAN      = HI - LO;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   state_t              state;
   state_t              state_nxt;
   logic                edge_p;
   logic [GATE_W-1:0]   gate_tmr;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    meas_count;
   logic                meas_valid;
   logic                freq_ok;
   logic                freq_fault;
   logic                stuck;
   logic                is_eval;
   logic                in_range;
   logic                is_zero;
   logic                fault_set;
   logic                stuck_set;

   osc_mon_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (CLK),
      .rst   (RESET),
      .d     (mon.MON_CLK),
      .pulse (edge_p)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: dropping ENABLE mid-measurement abandons the window.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (mon.ENABLE) state_nxt = ARM;
         ARM:  state_nxt = mon.ENABLE ? GATE : IDLE;
         GATE: begin
            if (!mon.ENABLE)            state_nxt = IDLE;
            else if (gate_tmr == GATE_LAST) state_nxt = EVAL;
         end
         EVAL: state_nxt = mon.ENABLE ? ARM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gate timer and saturating edge counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         gate_tmr <= '0;
         cnt      <= '0;
      end else if (state == ARM) begin
         gate_tmr <= '0;
         cnt      <= '0;
      end else if (state == GATE) begin
         gate_tmr <= gate_tmr + 1'b1;
         if (edge_p && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
   end

   // Unsigned wrap trick: below LO wraps to a huge offset beyond SPAN.
   always_comb begin
      is_eval  = (state == EVAL);
      in_range = !EMPTY && ((32'(cnt) - LO) <= SPAN);
      is_zero  = (cnt == '0);
   end

`ifdef OSC_MON_FILTER_EN
   logic prev_bad;
   logic prev_zero;
   logic abort;

   // Window history; forgotten on abort or explicit fault clear.
   always_comb begin
      abort     = (state == ARM || state == GATE) && !mon.ENABLE;
      fault_set = is_eval && !in_range && prev_bad;
      stuck_set = is_eval && is_zero && prev_zero;
   end

   // Previous-window bad/zero memory for the two-in-a-row filter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev_bad  <= 1'b0;
         prev_zero <= 1'b0;
      end else if (is_eval) begin
         prev_bad  <= !in_range;
         prev_zero <= is_zero;
      end else if (abort || mon.FAULT_CLR) begin
         prev_bad  <= 1'b0;
         prev_zero <= 1'b0;
      end
   end
`else
   // A single bad window is enough to raise the sticky flags.
   always_comb begin
      fault_set = is_eval && !in_range;
      stuck_set = is_eval && is_zero;
   end
`endif

   // Result registers; a flag set in EVAL beats a coincident clear.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         meas_count <= '0;
         meas_valid <= 1'b0;
         freq_ok    <= 1'b0;
         freq_fault <= 1'b0;
         stuck      <= 1'b0;
      end else begin
         meas_valid <= is_eval;
         if (is_eval) begin
            meas_count <= cnt;
            freq_ok    <= in_range;
         end
         freq_fault <= fault_set | (freq_fault & ~mon.FAULT_CLR);
         stuck      <= stuck_set | (stuck & ~mon.FAULT_CLR);
      end
   end

   assign mon.MEAS_COUNT = meas_count;
   assign mon.MEAS_VALID = meas_valid;
   assign mon.FREQ_OK    = freq_ok;
   assign mon.FREQ_FAULT = freq_fault;
   assign mon.STUCK      = stuck;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Randomised bench for osc_freq_monitor against a sample-history model.
// Honours OSC_MON_FILTER_EN for the two-window fault filter.
module tb_osc_freq_monitor;

   localparam int G  = 50;
   localparam int E  = 10;
   localparam int T  = 1;
   localparam int W  = 8;
   localparam int LO = (E - T < 0) ? 0 : E - T;
   localparam int HI = (E + T > 255) ? 255 : E + T;
   localparam int HN = 16384;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   osc_freq_monitor_if #(.CNT_W(W)) ifa ();
   osc_freq_monitor_if #(.CNT_W(3)) ifb ();

   osc_freq_monitor #(
      .SYNC_STAGES (2),
      .GATE_CYCLES (G),
      .EXP_COUNT   (E),
      .TOL         (T),
      .CNT_W       (W),
      .GATE_W      (8)
   ) u_dut (
      .CLK   (CLK),
      .RESET (RESET),
      .mon   (ifa)
   );

   osc_freq_monitor #(
      .SYNC_STAGES (2),
      .GATE_CYCLES (G),
      .EXP_COUNT   (E),
      .TOL         (T),
      .CNT_W       (3),
      .GATE_W      (8)
   ) u_dut_sat (
      .CLK   (CLK),
      .RESET (RESET),
      .mon   (ifb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int   mode = 0;
   logic lvl  = 1'b0;
   int   hi_len = 1;
   int   lo_len = 1;
   int   ph = 0;

   bit hist [HN];
   int cyc = 0;

   bit m_flt, m_stk, m_pb, m_pz;
   int last_v;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitored oscillator stimulus: level, periodic or random bits.
   always @(negedge CLK) begin
      case (mode)
         0: ifa.MON_CLK = lvl;
         1: begin
            ph++;
            if (ifa.MON_CLK === 1'b1 ? ph >= hi_len : ph >= lo_len) begin
               ifa.MON_CLK = (ifa.MON_CLK === 1'b1) ? 1'b0 : 1'b1;
               ph = 0;
            end
         end
         default: ifa.MON_CLK = 1'($urandom_range(0, 1));
      endcase
      ifb.MON_CLK = RESET ? 1'b0 : ~ifb.MON_CLK;
   end

   // Record what the design sees at every clock edge (reset reads as 0).
   always @(posedge CLK) begin
      if (cyc < HN) hist[cyc] = RESET ? 1'b0 : ifa.MON_CLK;
      cyc = cyc + 1;
   end

   // Rising edges visible at count edge c were sampled three edges earlier.
   function automatic int model_count(input int cv);
      int n = 0;
      for (int c = cv - G; c < cv; c++)
         if (c >= 4 && hist[c-3] && !hist[c-4]) n++;
      if (n > 255) n = 255;
      return n;
   endfunction

   task automatic model_clear();
      m_flt = 0;
      m_stk = 0;
      m_pb  = 0;
      m_pz  = 0;
   endtask

   task automatic window(input string tag);
      bit ok = 0;
      int cv, cnt;
      bit bad;
      for (int i = 0; i < 4 * G && !ok; i++) begin
         @(negedge CLK);
         ok = ifa.MEAS_VALID;
      end
      check({tag, "/valid"}, 32'(ok), 32'd1);
      if (!ok) return;
      cv  = cyc - 1;
      cnt = model_count(cv);
      bad = (cnt < LO) || (cnt > HI);
`ifdef OSC_MON_FILTER_EN
      if (bad && m_pb) m_flt = 1;
      if (cnt == 0 && m_pz) m_stk = 1;
      m_pb = bad;
      m_pz = (cnt == 0);
`else
      if (bad) m_flt = 1;
      if (cnt == 0) m_stk = 1;
`endif
      check({tag, "/count"}, 32'(ifa.MEAS_COUNT), 32'(cnt));
      check({tag, "/ok"}, 32'(ifa.FREQ_OK), 32'(!bad));
      check({tag, "/fault"}, 32'(ifa.FREQ_FAULT), 32'(m_flt));
      check({tag, "/stuck"}, 32'(ifa.STUCK), 32'(m_stk));
      check({tag, "/period"}, 32'(cv - last_v), 32'(G + 2));
      last_v = cv;
      @(negedge CLK);
      check({tag, "/pulse"}, 32'(ifa.MEAS_VALID), 32'd0);
   endtask

   task automatic fault_clear();
      ifa.FAULT_CLR = 1'b1;
      @(negedge CLK);
      ifa.FAULT_CLR = 1'b0;
      model_clear();
      check("clr/fault", 32'(ifa.FREQ_FAULT), 32'd0);
      check("clr/stuck", 32'(ifa.STUCK), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "/count"}, 32'(ifa.MEAS_COUNT), 32'd0);
      check({tag, "/valid"}, 32'(ifa.MEAS_VALID), 32'd0);
      check({tag, "/ok"}, 32'(ifa.FREQ_OK), 32'd0);
      check({tag, "/fault"}, 32'(ifa.FREQ_FAULT), 32'd0);
      check({tag, "/stuck"}, 32'(ifa.STUCK), 32'd0);
   endtask

   initial begin
      logic [W-1:0] held_cnt;
      logic         held_ok, held_flt, held_stk;
      int           seen;
      bit           okb;

      RESET = 1'b1;
      ifa.ENABLE = 1'b0;
      ifa.FAULT_CLR = 1'b0;
      ifb.ENABLE = 1'b0;
      ifb.FAULT_CLR = 1'b0;
      model_clear();
      repeat (3) @(negedge CLK);
      check_zero("reset");
      RESET = 1'b0;
      @(negedge CLK);

      // Nominal 5-clock oscillator: exactly E edges per window.
      mode = 1; hi_len = 3; lo_len = 2; ph = 0;
      ifa.ENABLE = 1'b1;
      last_v = cyc;
      window("p5a");
      window("p5b");
      check("p5b/exact", 32'(ifa.MEAS_COUNT), 32'd10);
      window("p5c");
      check("p5c/exact", 32'(ifa.MEAS_COUNT), 32'd10);

      // Fast 4-clock oscillator: out of range.
      hi_len = 2; lo_len = 2;
      window("p4a");
      window("p4b");
      window("p4c");

      // Stopped oscillator, then clear and re-detect.
      mode = 0; lvl = 1'b0;
      window("st0");
      window("st1");
      window("st2");
      fault_clear();
      window("st3");
      window("st4");

      // Abort at gate cycle 20.
      mode = 1; hi_len = 3; lo_len = 2;
      while (cyc < last_v + 21) @(negedge CLK);
      ifa.ENABLE = 1'b0;
      m_pb = 0;
      m_pz = 0;
      held_cnt = ifa.MEAS_COUNT;
      held_ok  = ifa.FREQ_OK;
      held_flt = ifa.FREQ_FAULT;
      held_stk = ifa.STUCK;
      seen = 0;
      repeat (3 * G) begin
         @(negedge CLK);
         if (ifa.MEAS_VALID) seen++;
      end
      check("abort/novalid", 32'(seen), 32'd0);
      check("abort/count", 32'(ifa.MEAS_COUNT), 32'(held_cnt));
      check("abort/ok", 32'(ifa.FREQ_OK), 32'(held_ok));
      check("abort/fault", 32'(ifa.FREQ_FAULT), 32'(held_flt));
      check("abort/stuck", 32'(ifa.STUCK), 32'(held_stk));
      ifa.ENABLE = 1'b1;
      last_v = cyc;
      window("reen");

      // Reset mid-gate while a fault is latched.
      mode = 0; lvl = 1'b0;
      window("rs0");
      window("rs1");
      check("rs/fault_set", 32'(ifa.FREQ_FAULT), 32'd1);
      repeat (10) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check_zero("midreset");
      model_clear();
      RESET = 1'b0;
      mode = 1; hi_len = 3; lo_len = 2; ph = 0;
      last_v = cyc;
      window("postrst");

      // Randomised oscillator shapes and occasional clears.
      for (int k = 0; k < 10; k++) begin
         mode   = int'($urandom_range(0, 2));
         lvl    = 1'($urandom_range(0, 1));
         hi_len = int'($urandom_range(1, 8));
         lo_len = int'($urandom_range(1, 8));
         if ($urandom_range(0, 3) == 0) fault_clear();
         window($sformatf("rnd%0d", k));
      end

      // Narrow counter saturates rather than wrapping.
      ifb.ENABLE = 1'b1;
      okb = 0;
      for (int i = 0; i < 4 * G && !okb; i++) begin
         @(negedge CLK);
         okb = ifb.MEAS_VALID;
      end
      check("sat/valid", 32'(okb), 32'd1);
      check("sat/count", 32'(ifb.MEAS_COUNT), 32'd7);
      check("sat/ok", 32'(ifb.FREQ_OK), 32'd0);
`ifdef OSC_MON_FILTER_EN
      check("sat/fault", 32'(ifb.FREQ_FAULT), 32'd0);
`else
      check("sat/fault", 32'(ifb.FREQ_FAULT), 32'd1);
`endif
      check("sat/stuck", 32'(ifb.STUCK), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/osc_freq_monitor.md
Name: osc_freq_monitor

Overview:
- Consumer-side check for the fabric oscillator outputs (RCOSC 1 MHz, XTLOSC or RCOSC 25/50 MHz O2F).
- Samples the monitored oscillator as asynchronous data in the system fabric clock domain and counts its rising edges over a fixed gate window.
- Compares the count against an expected value ± tolerance and reports the count, an in-range flag, a sticky fault and a stuck-clock flag.
- Sits beside the OSC wrapper in the UART subsystem so firmware can detect a missing or off-frequency oscillator before trusting baud timing.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on MON_CLK (≥2).
- GATE_CYCLES, 50000, CLK cycles per measurement window (1 ms at 50 MHz).
- EXP_COUNT, 1000, expected MON_CLK rising edges per window.
- TOL, 10, allowed ± deviation from EXP_COUNT, inclusive.
- CNT_W, 16, width of the edge counter and MEAS_COUNT.
- GATE_W, 16, width of the gate timer; must hold GATE_CYCLES-1.

Ports:
- CLK  in  1  fabric clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  level; 1 = measure continuously, 0 = idle.
- MON_CLK  in  1  monitored oscillator; asynchronous to CLK.
- FAULT_CLR  in  1  one-cycle pulse; clears FREQ_FAULT and STUCK.
- MEAS_COUNT  out  CNT_W  edge count of the last completed window.
- MEAS_VALID  out  1  one-cycle pulse when MEAS_COUNT updates.
- FREQ_OK  out  1  last completed window was within EXP_COUNT±TOL.
- FREQ_FAULT  out  1  sticky; set on any out-of-range window.
- STUCK  out  1  sticky; set when a window saw zero edges.

Behaviour:
- Reset: state IDLE. MEAS_COUNT=0, MEAS_VALID=0, FREQ_OK=0, FREQ_FAULT=0, STUCK=0. Synchroniser, edge register, gate timer and edge counter all 0.
- Synchroniser: MON_CLK passes through SYNC_STAGES flops. A rising edge is registered sync=1 with previous=0. Edge-detect latency is SYNC_STAGES+1 cycles.
- Detectable MON_CLK frequency must be below CLK/2. Higher frequencies alias and are reported as out of range.
- FSM states:
  - IDLE: wait for ENABLE=1, then go to ARM.
  - ARM: one cycle. Clear gate timer and edge counter, then go to GATE.
  - GATE: exactly GATE_CYCLES cycles. Each cycle with a detected edge increments the counter. An edge on the final gate cycle is counted. The counter saturates at 2^CNT_W-1 and does not wrap. After the last gate cycle, go to EVAL.
  - EVAL: one cycle. MEAS_COUNT<=count; MEAS_VALID=1; FREQ_OK<=(EXP_COUNT-TOL ≤ count ≤ EXP_COUNT+TOL). If out of range, set FREQ_FAULT. If count==0, set STUCK. Next state is ARM if ENABLE=1, else IDLE.
- Window period is GATE_CYCLES+2 CLK cycles. Edges arriving during ARM/EVAL are not counted, by design.
- Range bounds are computed at elaboration with clamping: the lower bound is clamped at 0 and the upper bound at 2^CNT_W-1.
- ENABLE=0 during ARM or GATE aborts to IDLE next cycle. No MEAS_VALID is issued. MEAS_COUNT, FREQ_OK and the sticky flags hold their values.
- FAULT_CLR clears FREQ_FAULT and STUCK. If FAULT_CLR coincides with an EVAL that sets a flag, the set wins.
- RESET asserted in any state returns to the reset values on the next edge and overrides all other inputs.

Optional Feature:
- Macro: OSC_MON_FILTER_EN.
- Defined: FREQ_FAULT sets only after two consecutive out-of-range windows.
  - A 1-bit "previous bad" register updates in each EVAL. It is cleared by RESET, by an abort and by FAULT_CLR.
  - STUCK also requires two consecutive zero-count windows.
  - FREQ_OK still reflects the single latest window.
- Not defined: a single bad window sets the flags, as described above.

Decomposition:
- Shared package osc_mon_pkg holds:
  - FSM state enum: IDLE, ARM, GATE, EVAL.
  - Default parameter constants.
  - A function computing the clamped lower and upper bounds.
- One sub-module: osc_mon_sync_edge. It contains the SYNC_STAGES synchroniser and the rising-edge detector, outputting a one-cycle edge pulse. It is reusable for other asynchronous strobes in the UART subsystem.

Test Plan (sim params GATE_CYCLES=50, EXP_COUNT=10, TOL=1, CNT_W=8):
- MON_CLK period 5 CLK, ENABLE=1 → MEAS_VALID every 52 cycles; MEAS_COUNT=10; FREQ_OK=1; FREQ_FAULT=0; STUCK=0.
- MON_CLK period 4 CLK → MEAS_COUNT=12 or 13; FREQ_OK=0; FREQ_FAULT=1 after the first EVAL (filter off) or the second EVAL (filter on).
- MON_CLK held at 0 → MEAS_COUNT=0; STUCK=1; FREQ_FAULT=1. FAULT_CLR pulse on a non-EVAL cycle → both flags 0, then set again at the next EVAL.
- ENABLE dropped at gate cycle 20 → IDLE next cycle; no MEAS_VALID; MEAS_COUNT keeps its previous value. Re-enable → ARM, then a full 50-cycle window.
- CNT_W=3, MON_CLK period 2 CLK → MEAS_COUNT=7 (saturated, no wrap); FREQ_OK=0.
- RESET pulsed mid-GATE with FREQ_FAULT=1 → all outputs 0 next cycle; state IDLE; a fresh window starts after RESET deasserts with ENABLE=1.
